// File: rtl/uart_tx_fifo_if.sv
// Bus-side write port and transmitter handshake of the UART0 transmit queue.
// The queue takes the slave modport; the bus/transmitter side takes the master modport.
interface uart_tx_fifo_if #(
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [7:0]        wr_data;
    logic              flush;
    logic              clear_overflow;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              busy;
    logic              tx_enable;
    logic [7:0]        tx_data;
    logic              tx_done;

    modport master (
        output wr_en, wr_data, flush, clear_overflow, tx_done,
        input  full, empty, count, overflow, busy, tx_enable, tx_data
    );

    modport slave (
        input  wr_en, wr_data, flush, clear_overflow, tx_done,
        output full, empty, count, overflow, busy, tx_enable, tx_data
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between bus writes to UART0 data and the serial transmitter;
// a three-state launcher drains one byte per uart_tx frame.
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_fifo_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE   = 1;
    localparam logic [ADDR_W-1:0] PTR_ONE   = 1;

    state_t            state_q, state_d;
    logic [7:0]        mem_q [DEPTH];
    logic [7:0]        mem_d [DEPTH];
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              tx_enable_q, tx_enable_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              full, empty, push, pop;

    // full is judged on the pre-edge count, so a write while full is lost
    // even when the launcher frees a slot on the same edge.
    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == '0);
    assign push  = bus.wr_en && !full;
    assign pop   = (state_q == IDLE) && !empty && bus.tx_done && !bus.flush;

    always_comb begin
        mem_d = mem_q;
        if (push && !bus.flush) begin
            mem_d[wr_ptr_q] = bus.wr_data;
        end
    end

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (bus.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push && !pop)      count_d = count_q + CNT_ONE;
            else if (pop && !push) count_d = count_q - CNT_ONE;
        end
        if (bus.wr_en && full)         overflow_d = 1'b1;
        else if (bus.clear_overflow)   overflow_d = 1'b0;
    end

    always_comb begin
        state_d     = state_q;
        tx_enable_d = 1'b0;
        tx_data_d   = tx_data_q;
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    tx_data_d   = mem_q[rd_ptr_q];
                    tx_enable_d = 1'b1;
                    state_d     = WAIT_BUSY;
                end
            end
            WAIT_BUSY: if (!bus.tx_done) state_d = WAIT_DONE;
            WAIT_DONE: if (bus.tx_done)  state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Storage carries no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tx_enable_q <= 1'b0;
            tx_data_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            tx_enable_q <= tx_enable_d;
            tx_data_q   <= tx_data_d;
        end
    end

    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.busy      = !empty || (state_q != IDLE);
    assign bus.tx_enable = tx_enable_q;
    assign bus.tx_data   = tx_data_q;
endmodule
